// File: rtl/loop_sampler.sv
// -----------------------------------------------------------------------------
// loop_sampler
//   Audio loop engine between the codec sample path and the output mixer.
//   Records a sample stream into on-chip RAM, plays it back forward or reversed
//   at half, normal or double speed, and overdubs new input onto the stored
//   loop with saturating addition. All work advances on `tick`, a one-clk pulse
//   taken from the rising edge of the codec sample clock.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   rwClk           codec sample clock (level)
//   in              signed input sample
//   write           record request (highest priority)
//   overdub         overdub request
//   read            playback request (lowest priority)
//   reverse         playback direction, 1 = decreasing address
//   speed           00/11 normal, 01 double, 10 half
//   out             output sample
//   state           IDLE=00 RECORD=01 PLAY=10 OVERDUB=11
//   loopExists      a sample has been recorded since reset / take start
//   loopMax         last valid loop address (loop length = loopMax+1)
// -----------------------------------------------------------------------------
module loop_sampler #(
   parameter int DATA_WIDTH = 24,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rwClk,
   input  logic [DATA_WIDTH-1:0] in,
   input  logic                  write,
   input  logic                  overdub,
   input  logic                  read,
   input  logic                  reverse,
   input  logic [1:0]            speed,
   output logic [DATA_WIDTH-1:0] out,
   output logic [1:0]            state,
   output logic                  loopExists,
   output logic [ADDR_WIDTH-1:0] loopMax
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_RECORD  = 2'b01,
      S_PLAY    = 2'b10,
      S_OVERDUB = 2'b11
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] A_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   AW_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [DATA_WIDTH-1:0] D_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] D_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   state_t                  r_state;
   logic                    r_rwClkPrev;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [ADDR_WIDTH-1:0]   r_loopMax;
   logic                    r_loopExists;
   logic                    r_phase;
   logic                    r_takeDone;   // take ended by memory-full; wait for write release
   logic                    r_odPend;     // overdub write-back due this cycle
   logic [ADDR_WIDTH-1:0]   r_odAddr;
   logic [DATA_WIDTH-1:0]   r_odIn;
   logic [DATA_WIDTH-1:0]   r_memQ;
   logic [DATA_WIDTH-1:0]   r_outReg;
   logic                    r_outSel;     // 1: out shows the RAM read register
   logic [DATA_WIDTH-1:0]   r_mem [2**ADDR_WIDTH];

   // --------------------------------------------------------------------------
   // Wires
   // --------------------------------------------------------------------------
   state_t                  w_nxt;
   logic                    w_tick;
   logic                    w_wr;
   logic                    w_recEnd;
   logic                    w_adv;
   logic [1:0]              w_step;
   logic                    w_we;
   logic                    w_re;
   logic [ADDR_WIDTH-1:0]   w_ma;
   logic [DATA_WIDTH-1:0]   w_wd;
   logic [DATA_WIDTH:0]     w_sumW;
   logic [DATA_WIDTH-1:0]   w_sum;

   // Address step with wrap inside [0, loopMax]; done one bit wider so the
   // forward sum cannot overflow before the compare.
   function automatic logic [ADDR_WIDTH-1:0] f_step(
      input logic [ADDR_WIDTH-1:0] a,
      input logic [ADDR_WIDTH-1:0] mx,
      input logic [1:0]            st,
      input logic                  rev
   );
      logic [ADDR_WIDTH:0] wa, wlen, ws, wr;
      wa   = {1'b0, a};
      wlen = {1'b0, mx} + AW_ONE;
      ws   = {{(ADDR_WIDTH-1){1'b0}}, st};
      if (mx == '0)
         wr = '0;
      else if (!rev)
         wr = ((wa + ws) > {1'b0, mx}) ? (wa + ws - wlen) : (wa + ws);
      else
         wr = (wa < ws) ? (wa + wlen - ws) : (wa - ws);
      return wr[ADDR_WIDTH-1:0];
   endfunction

   assign w_tick   = rwClk & ~r_rwClkPrev;
   assign w_wr     = write & ~r_takeDone;
   assign w_recEnd = (r_state == S_RECORD) && w_tick && (r_addr == '1);
   assign w_step   = (speed == 2'b01) ? 2'd2 : 2'd1;
   // Half speed: address moves only on every second tick.
   assign w_adv    = (speed != 2'b10) || r_phase;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      w_nxt = S_IDLE;
      if (w_wr)
         w_nxt = w_recEnd ? (read ? S_PLAY : S_IDLE) : S_RECORD;
      else if (overdub && r_loopExists)
         w_nxt = S_OVERDUB;
      else if (read && r_loopExists)
         w_nxt = S_PLAY;
   end

   // --------------------------------------------------------------------------
   // Saturating overdub sum (RAM read register + latched input)
   // --------------------------------------------------------------------------
   always_comb begin
      w_sumW = {r_memQ[DATA_WIDTH-1], r_memQ} + {r_odIn[DATA_WIDTH-1], r_odIn};
      w_sum  = w_sumW[DATA_WIDTH-1:0];
      if (w_sumW[DATA_WIDTH] != w_sumW[DATA_WIDTH-1])
         w_sum = w_sumW[DATA_WIDTH] ? D_MIN : D_MAX;
   end

   // --------------------------------------------------------------------------
   // Single-port RAM: record writes and overdub write-backs share the port
   // with playback/overdub reads. Tick spacing keeps them in separate cycles.
   // --------------------------------------------------------------------------
   always_comb begin
      w_we = 1'b0;
      w_re = 1'b0;
      w_ma = r_addr;
      w_wd = in;
      if (!reset) begin
         if (r_odPend) begin
            w_we = 1'b1;
            w_ma = r_odAddr;
            w_wd = w_sum;
         end else if (w_tick) begin
            w_we = (r_state == S_RECORD);
            w_re = (r_state == S_PLAY) || (r_state == S_OVERDUB);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_ma] <= w_wd;
      if (w_re) r_memQ      <= r_mem[w_ma];
   end

   // --------------------------------------------------------------------------
   // State register and datapath
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_rwClkPrev  <= 1'b0;
         r_addr       <= '0;
         r_loopMax    <= '0;
         r_loopExists <= 1'b0;
         r_phase      <= 1'b0;
         r_takeDone   <= 1'b0;
         r_odPend     <= 1'b0;
         r_odAddr     <= '0;
         r_odIn       <= '0;
         r_outReg     <= '0;
         r_outSel     <= 1'b0;
      end else begin
         r_rwClkPrev <= rwClk;
         r_state     <= w_nxt;
         r_takeDone  <= write & (r_takeDone | w_recEnd);
         r_odPend    <= 1'b0;

         // Tick work always follows the state held during the tick cycle.
         case (r_state)
            S_IDLE: if (w_tick) begin
               r_outReg <= in;
               r_outSel <= 1'b0;
            end
            S_RECORD: if (w_tick) begin
               r_outReg     <= in;
               r_outSel     <= 1'b0;
               r_loopMax    <= r_addr;
               r_loopExists <= 1'b1;
               r_addr       <= r_addr + A_ONE;
            end
            S_PLAY: if (w_tick) begin
               r_outSel <= 1'b1;
               if (speed == 2'b10) r_phase <= ~r_phase;
               if (w_adv) r_addr <= f_step(r_addr, r_loopMax, w_step, reverse);
            end
            S_OVERDUB: if (w_tick) begin
               // Freeze the visible sample while the RAM read register is reused.
               r_outReg <= out;
               r_outSel <= 1'b0;
               r_odPend <= 1'b1;
               r_odAddr <= r_addr;
               r_odIn   <= in;
            end
         endcase

         if (r_odPend) begin
            r_outReg <= w_sum;
            r_outSel <= 1'b0;
            r_addr   <= f_step(r_addr, r_loopMax, 2'd1, 1'b0);
         end

         // Address side effects of a state change win over tick work.
         if (w_nxt == S_RECORD && r_state != S_RECORD) begin
            r_addr       <= '0;
            r_loopMax    <= '0;
            r_loopExists <= 1'b0;
            r_phase      <= 1'b0;
         end else if (r_state == S_RECORD && w_nxt != S_RECORD) begin
            r_addr <= '0;
         end
      end
   end

   assign out        = r_outSel ? r_memQ : r_outReg;
   assign state      = r_state;
   assign loopExists = r_loopExists;
   assign loopMax    = r_loopMax;

endmodule

// File: doc/loop_sampler.md
# loop_sampler

Parametrised multi-mode audio loop engine that sits between the codec sample path and the output mixer. It records a sample stream into on-chip memory, then plays it back. Playback runs forward or reversed at half, normal or double speed. It can also overdub new input onto the stored loop with saturating addition. All work advances once per sample strobe, which is derived internally from the codec's sample clock.

## Interface
- `DATA_WIDTH`, 24, signed sample width.
- `ADDR_WIDTH`, 16, loop memory depth is 2**ADDR_WIDTH samples.
- `clk` input 1: system clock; single clock domain.
- `reset` input 1: synchronous, active-high.
- `rwClk` input 1: codec sample clock (level). Rising edge detected internally, giving a one-`clk` pulse `tick`.
- `in` input DATA_WIDTH: signed input sample.
- `write` input 1: record request (level).
- `overdub` input 1: overdub request (level).
- `read` input 1: playback request (level).
- `reverse` input 1: playback direction; 1 means decreasing address.
- `speed` input 2: 00 normal, 01 double, 10 half, 11 normal.
- `out` output DATA_WIDTH: registered output sample.
- `state` output 2: IDLE=00, RECORD=01, PLAY=10, OVERDUB=11.
- `loopExists` output 1: at least one sample recorded since the last reset or new take.
- `loopMax` output ADDR_WIDTH: last valid loop address; loop length is loopMax+1.

## Operation
- Edge detect: `tick = rwClk & ~rwClkPrev`. `rwClkPrev` is registered every clk and cleared by reset.
- Command priority: write > overdub > read. It is evaluated every clk.
- State transitions:
  - Any state + write → RECORD.
  - Entering RECORD from another state sets addr=0, loopMax=0, loopExists=0 and the speed phase to 0.
  - RECORD with write low → PLAY if read, else IDLE. Either way addr=0.
  - write low, overdub high, loopExists → OVERDUB. If loopExists=0, the request is ignored and the state becomes IDLE.
  - write low, overdub low, read high, loopExists → PLAY. If loopExists=0 → IDLE.
  - No request → IDLE. addr is held, so a later PLAY resumes at that address.
  - PLAY ↔ OVERDUB switches keep addr.
- RECORD, on tick:
  - mem[addr] ← in; loopMax ← addr; loopExists ← 1; addr ← addr+1.
  - If addr == 2**ADDR_WIDTH-1, that sample is written, addr ← 0, and the state is forced to PLAY when read=1, otherwise IDLE.
  - The take then ends. It does not restart unless write is deasserted and reasserted.
- PLAY, on an advance tick:
  - out ← mem[addr], then addr steps by `step`.
  - step = 2 for double, else 1.
  - Half speed: a phase bit toggles on every tick; addr advances only on ticks where phase was 1. out is reloaded every tick, so each sample is output twice.
  - Forward wrap: if addr+step > loopMax, new addr = addr+step-(loopMax+1).
  - Reverse wrap: if addr < step, new addr = addr+(loopMax+1)-step.
  - Arithmetic is done at ADDR_WIDTH+1 bits.
  - When loopMax=0, addr stays 0.
- OVERDUB, on tick:
  - Read mem[addr] in the tick cycle.
  - In the next clk, compute `sum = sat(mem[addr] + in)` and write it to mem[addr]. Also out ← sum.
  - Then addr steps forward by 1, wrapping at loopMax. reverse and speed are ignored.
  - Saturation: the add is done at DATA_WIDTH+1 bits and clamped to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1].
- IDLE and RECORD: out ← in on tick (registered passthrough).
- Memory: one read/write port, inferred as block RAM. Memory contents are not cleared by reset.

## Timing
- Reset values: out=0, state=IDLE, loopExists=0, loopMax=0, addr=0, phase=0, rwClkPrev=0.
- reset dominates all inputs in the same cycle. Reset mid-take or mid-overdub aborts it; a pending overdub write is dropped.
- tick is high in the first clk where rwClk is sampled high after being low.
- Latency: out changes on the clk edge at the end of the tick cycle (1 clk) in IDLE, RECORD and PLAY. In OVERDUB it changes 2 clk after tick.
- Ticks are required to be at least 4 clk apart.
- State changes take effect at the next clk edge. A tick in the same cycle as a state change is processed under the old state.

## Test plan
- Test parameters: ADDR_WIDTH=4, DATA_WIDTH=24. Stimulus: ticks every 8 clk, in = tick index.
- Record in=1..5 with write high for 5 ticks, then drop write and raise read → loopMax=4, loopExists=1. out sequence: 1,2,3,4,5,1,2.
- Same loop with reverse=1 from addr 0 → out: 1,5,4,3,2,1,5.
- Same loop with speed=01 → out 1,3,5,2,4,1. With speed=10 → out 1,1,2,2,3,3.
- Overdub the 5-sample loop with in=10 for 5 ticks, then play → out 11..15. Separately, stored 0x7FFFF0 overdubbed with 0x20 → out 0x7FFFFF; 0x800010 overdubbed with 0xFFFFE0 (-0x20) → 0x800000.
- Hold write for 20 ticks with read=1 → after the 16th sample, state=PLAY, loopMax=15, first played sample = sample 1 (wrapped).
- read=1 right after reset (no loop) → state=IDLE, out follows in. Assert reset during PLAY → out=0, state=IDLE, loopExists=0 next clk.
